// File: rtl/xalu_nibble_seq.sv
// xalu_nibble_seq: runs a 4-bit ALU slice once per nibble to build a NIBBLES*4-bit result and word flags
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic                 com,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 zero,
  output logic                 neg_zero,
  output logic                 equ,
  output logic [3:0]           sl_a,
  output logic [3:0]           sl_b,
  output logic [2:0]           sl_f,
  output logic                 sl_ci_right,
  output logic                 sl_ci_left,
  output logic                 sl_com,
  input  logic [3:0]           sl_d,
  input  logic                 sl_co_left,
  input  logic                 sl_co_right,
  input  logic                 sl_equ
);
  localparam int W = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] ra, rb, acc, acc_nxt;
  logic [2:0] rop;
  logic rcom, rcin, carry, eq_acc;
  logic [KW-1:0] k, idx;
  logic run, shr, last, ci, co;
  always_comb begin
    run = state == RUN;
    shr = rop == 3'd6;
    idx = shr ? KW'(NIBBLES - 1) - k : k;
    last = k == KW'(NIBBLES - 1);
    ci = k == '0 ? rcin : carry;
    co = shr ? sl_co_right : sl_co_left;
    acc_nxt = acc;
    acc_nxt[{idx, 2'b00} +: 4] = sl_d;
    sl_a = run ? ra[{idx, 2'b00} +: 4] : '0;
    sl_b = run ? rb[{idx, 2'b00} +: 4] : '0;
    sl_f = run ? rop : '0;
    sl_com = run & rcom;
    sl_ci_right = run & ~shr & ci;
    sl_ci_left = run & shr & ci;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
      neg_zero <= 1'b0;
      equ <= 1'b0;
      ra <= '0;
      rb <= '0;
      rop <= '0;
      rcom <= 1'b0;
      rcin <= 1'b0;
      acc <= '0;
      k <= '0;
      carry <= 1'b0;
      eq_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra <= a;
          rb <= b;
          rop <= op;
          rcom <= com;
          rcin <= cin;
          acc <= '0;
          k <= '0;
          carry <= 1'b0;
          eq_acc <= 1'b1;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          acc <= acc_nxt;
          carry <= co;
          eq_acc <= eq_acc & sl_equ;
          k <= k + 1'b1;
          // publish the whole word at once so result never shows a partial value
          if (last) begin
            result <= acc_nxt;
            cout <= co;
            zero <= acc_nxt == '0;
            neg_zero <= &acc_nxt;
            equ <= eq_acc & sl_equ;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xalu_nibble_seq.sv
// tb_xalu_nibble_seq: self-checking bench with a nibble slice model and a word-level reference model
module tb_xalu_nibble_seq;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 0, rst = 1, start = 0, com = 0, cin = 0;
  logic [2:0] op = 0;
  logic [W-1:0] a = 0, b = 0;
  logic busy, done, cout, zero, neg_zero, equ;
  logic [W-1:0] result;
  logic [3:0] sl_a, sl_b, sl_d;
  logic [2:0] sl_f;
  logic sl_ci_right, sl_ci_left, sl_com, sl_co_left, sl_co_right, sl_equ;
  int total = 0, bad = 0;
  int lat, nrec;
  logic [3:0] seq_a [8];
  logic seq_cr [8];
  logic [W-1:0] r_res;
  logic r_cout, r_zero, r_neg, r_equ, done_after, busy_after;

  xalu_nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .com(com), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .neg_zero(neg_zero), .equ(equ), .sl_a(sl_a), .sl_b(sl_b), .sl_f(sl_f),
    .sl_ci_right(sl_ci_right), .sl_ci_left(sl_ci_left), .sl_com(sl_com),
    .sl_d(sl_d), .sl_co_left(sl_co_left), .sl_co_right(sl_co_right), .sl_equ(sl_equ)
  );

  always #5 clk = ~clk;

  // behavioural 4-bit slice
  logic [4:0] s5;
  always_comb begin
    s5 = {1'b0, sl_a} + {1'b0, sl_b} + {4'b0, sl_ci_right};
    sl_d = 4'h0;
    sl_co_left = 1'b0;
    sl_co_right = 1'b0;
    case (sl_f)
      3'd0: {sl_co_left, sl_d} = s5;
      3'd1: sl_d = sl_a & sl_b;
      3'd2: sl_d = sl_a | sl_b;
      3'd3: sl_d = sl_a ^ sl_b;
      3'd4: sl_d = sl_a;
      3'd5: sl_d = sl_b;
      3'd6: begin sl_d = {sl_ci_left, sl_a[3:1]}; sl_co_right = sl_a[0]; end
      default: begin sl_d = {sl_a[2:0], sl_ci_right}; sl_co_left = sl_a[3]; end
    endcase
    if (sl_com) sl_d = ~sl_d;
    sl_equ = sl_a == sl_b;
  end

  function automatic void model(input logic [2:0] o, input logic c, input logic [W-1:0] xa, xb,
                                input logic ci, output logic [W-1:0] r, output logic co);
    logic [W:0] s;
    s = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, ci};
    co = 1'b0;
    case (o)
      3'd0: begin r = s[W-1:0]; co = s[W]; end
      3'd1: r = xa & xb;
      3'd2: r = xa | xb;
      3'd3: r = xa ^ xb;
      3'd4: r = xa;
      3'd5: r = xb;
      3'd6: begin r = {ci, xa[W-1:1]}; co = xa[0]; end
      default: begin r = {xa[W-2:0], ci}; co = xa[W-1]; end
    endcase
    if (c) r = ~r;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic c, input logic [W-1:0] xa, xb, input logic ci);
    @(negedge clk);
    op = o; com = c; a = xa; b = xb; cin = ci; start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = -1;
    nrec = 0;
    for (int e = 1; e <= 20 && lat < 0; e++) begin
      if (nrec < 8) begin seq_a[nrec] = sl_a; seq_cr[nrec] = sl_ci_right; nrec++; end
      @(posedge clk);
      #1;
      if (done) lat = e;
    end
    r_res = result; r_cout = cout; r_zero = zero; r_neg = neg_zero; r_equ = equ;
    @(posedge clk);
    #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if ({cout, zero, neg_zero, equ} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {cout, zero, neg_zero, equ}); end
    total++; if ({sl_a, sl_b, sl_f, sl_ci_right, sl_ci_left, sl_com} !== 14'b0) begin bad++; $display("FAIL reset_slice got=%h exp=0", {sl_a, sl_b, sl_f}); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_add;
    run_op(3'd0, 1'b0, 16'h0FFF, 16'h0001, 1'b0);
    total++; if (lat !== N) begin bad++; $display("FAIL add1_latency got=%0d exp=%0d", lat, N); end
    total++; if (r_res !== 16'h1000) begin bad++; $display("FAIL add1_result got=%h exp=1000", r_res); end
    total++; if ({r_cout, r_zero, r_neg, r_equ} !== 4'b0000) begin bad++; $display("FAIL add1_flags got=%b exp=0000", {r_cout, r_zero, r_neg, r_equ}); end
    total++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin bad++; $display("FAIL add1_done_pulse got=%b%b exp=00", done_after, busy_after); end
    run_op(3'd0, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    total++; if (r_res !== 16'h0000) begin bad++; $display("FAIL add2_result got=%h exp=0000", r_res); end
    total++; if ({r_cout, r_zero, r_neg} !== 3'b110) begin bad++; $display("FAIL add2_flags got=%b exp=110", {r_cout, r_zero, r_neg}); end
    total++; if ({seq_cr[0], seq_cr[1], seq_cr[2], seq_cr[3]} !== 4'b0111) begin bad++; $display("FAIL add2_ci_right got=%b exp=0111", {seq_cr[0], seq_cr[1], seq_cr[2], seq_cr[3]}); end
  endtask

  task automatic test_shift;
    run_op(3'd7, 1'b0, 16'h8001, 16'h0000, 1'b1);
    total++; if (r_res !== 16'h0003 || r_cout !== 1'b1) begin bad++; $display("FAIL shl got=%h/%b exp=0003/1", r_res, r_cout); end
    run_op(3'd6, 1'b0, 16'h8001, 16'h0000, 1'b0);
    total++; if (r_res !== 16'h4000 || r_cout !== 1'b1) begin bad++; $display("FAIL shr got=%h/%b exp=4000/1", r_res, r_cout); end
    total++; if ({seq_a[0], seq_a[1], seq_a[2], seq_a[3]} !== 16'h8001) begin bad++; $display("FAIL shr_sl_a_seq got=%h exp=8001", {seq_a[0], seq_a[1], seq_a[2], seq_a[3]}); end
  endtask

  task automatic test_xor_com;
    run_op(3'd3, 1'b1, 16'h1234, 16'h1234, 1'b0);
    total++; if (r_res !== 16'hFFFF) begin bad++; $display("FAIL xor_com_result got=%h exp=ffff", r_res); end
    total++; if ({r_neg, r_zero, r_equ, r_cout} !== 4'b1010) begin bad++; $display("FAIL xor_com_flags got=%b exp=1010", {r_neg, r_zero, r_equ, r_cout}); end
  endtask

  task automatic test_busy_ignore;
    int dones;
    logic [W-1:0] first;
    dones = 0;
    first = '0;
    @(negedge clk);
    op = 3'd0; com = 0; a = 16'h1111; b = 16'h2222; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #1 start = 1; op = 3'd3; a = 16'hFFFF; b = 16'h0F0F;
    repeat (2) @(posedge clk);
    #1 start = 0;
    for (int e = 0; e < 12; e++) begin
      if (done) begin dones++; first = result; end
      @(posedge clk);
      #1;
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
    total++; if (first !== 16'h3333) begin bad++; $display("FAIL busy_result got=%h exp=3333", first); end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    op = 3'd4; com = 0; a = 16'h5555; b = 16'h0; cin = 0; start = 1;
    @(posedge clk);
    #1 start = 0;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL abort_ctrl got=%b exp=00", {busy, done}); end
    total++; if (result !== '0) begin bad++; $display("FAIL abort_result got=%h exp=0", result); end
    total++; if (sl_a !== 4'h0) begin bad++; $display("FAIL abort_sl_a got=%h exp=0", sl_a); end
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_stays_idle got=%b exp=0", busy); end
    run_op(3'd5, 1'b0, 16'h0000, 16'hA5C3, 1'b0);
    total++; if (r_res !== 16'hA5C3) begin bad++; $display("FAIL abort_passb got=%h exp=a5c3", r_res); end
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic c, ci;
    logic [W-1:0] xa, xb, er;
    logic ec;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7));
      c = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      xa = 16'($urandom);
      xb = ($urandom_range(0, 3) == 0) ? xa : 16'($urandom);
      if ($urandom_range(0, 9) == 0) xa = 16'hFFFF;
      model(o, c, xa, xb, ci, er, ec);
      run_op(o, c, xa, xb, ci);
      total++; if (lat !== N) begin bad++; $display("FAIL rnd_latency i=%0d got=%0d exp=%0d", i, lat, N); end
      total++; if (r_res !== er) begin bad++; $display("FAIL rnd_result i=%0d op=%0d got=%h exp=%h", i, o, r_res, er); end
      total++; if (r_cout !== ec) begin bad++; $display("FAIL rnd_cout i=%0d op=%0d got=%b exp=%b", i, o, r_cout, ec); end
      total++; if (r_zero !== (er == '0) || r_neg !== (&er)) begin bad++; $display("FAIL rnd_zflags i=%0d got=%b%b exp=%b%b", i, r_zero, r_neg, er == '0, &er); end
      total++; if (r_equ !== (xa == xb)) begin bad++; $display("FAIL rnd_equ i=%0d got=%b exp=%b", i, r_equ, xa == xb); end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_shift;
    test_xor_com;
    test_busy_ignore;
    test_reset_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
